// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types and fetch-stage definitions
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        KILL   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam word_t FETCH_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry {instr, pc} hold register
// Ports: clk/rst_n (async active-low), load captures {capture_instr, capture_pc},
//        clear drops the entry; instr/pc/valid present the stored entry.
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  clear,
    input  word_t capture_instr,
    input  word_t capture_pc,
    output word_t instr,
    output word_t pc,
    output logic  valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= capture_instr;
            pc    <= capture_pc;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the IF/ID latch
// Ports: CLK/nRST (async active-low); icache ihit/iload/imemREN/imemaddr;
//        stall, redirect_valid/redirect_pc, halt from downstream;
//        instr_o/npc_o/curr_pc_o/latch_en/latch_flush/latch_freeze to the latch.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t       RESET_PC = FETCH_RESET_PC,
    parameter int unsigned PC_INC   = 4
)
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  ihit,
    input  word_t iload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t instr_o,
    output word_t npc_o,
    output word_t curr_pc_o,
    output logic  latch_en,
    output logic  latch_flush,
    output logic  latch_freeze
);

    localparam word_t INC = word_t'(PC_INC);

    fetch_state_t state, state_n;
    word_t pc, pc_n, kill_addr, kill_addr_n, target, target_n;
    word_t last_instr, last_pc, last_npc;
    word_t d_instr, d_pc, d_npc, addr, new_target;
    logic  req, en, flush, buf_load, buf_clear, buf_valid;
    word_t buf_instr, buf_pc;

    fetch_hold_buf u_hold_buf (
        .clk           (CLK),
        .rst_n         (nRST),
        .load          (buf_load),
        .clear         (buf_clear),
        .capture_instr (iload),
        .capture_pc    (pc),
        .instr         (buf_instr),
        .pc            (buf_pc),
        .valid         (buf_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            kill_addr  <= '0;
            target     <= '0;
            last_instr <= '0;
            last_pc    <= '0;
            last_npc   <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            kill_addr  <= kill_addr_n;
            target     <= target_n;
            // Data outputs stay at their last value when nothing new is shown.
            last_instr <= d_instr;
            last_pc    <= d_pc;
            last_npc   <= d_npc;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        kill_addr_n = kill_addr;
        target_n    = target;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        req         = 1'b0;
        addr        = pc;
        en          = 1'b0;
        flush       = 1'b0;
        d_instr     = last_instr;
        d_pc        = last_pc;
        d_npc       = last_npc;
        new_target  = redirect_valid ? word_align(redirect_pc) : target;

        unique case (state)
            FETCH: begin
                req = 1'b1;
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect_valid) begin
                    flush = 1'b1;
                    if (ihit) begin
                        pc_n = word_align(redirect_pc);
                    end else begin
                        // Keep the miss address on the bus until it completes.
                        kill_addr_n = pc;
                        target_n    = word_align(redirect_pc);
                        state_n     = KILL;
                    end
                end else if (ihit) begin
                    if (stall) begin
                        buf_load = 1'b1;
                        state_n  = HOLD;
                    end else begin
                        en      = 1'b1;
                        d_instr = iload;
                        d_pc    = pc;
                        d_npc   = pc + INC;
                        pc_n    = pc + INC;
                    end
                end
            end
            HOLD: begin
                d_instr = buf_instr;
                d_pc    = buf_pc;
                d_npc   = buf_pc + INC;
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect_valid) begin
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                    pc_n      = word_align(redirect_pc);
                    state_n   = FETCH;
                end else if (!stall && buf_valid) begin
                    en        = 1'b1;
                    buf_clear = 1'b1;
                    pc_n      = buf_pc + INC;
                    state_n   = FETCH;
                end
            end
            KILL: begin
                req  = 1'b1;
                addr = kill_addr;
                if (halt) begin
                    state_n = HALTED;
                end else begin
                    flush = redirect_valid;
                    if (ihit) begin
                        pc_n    = new_target;
                        state_n = FETCH;
                    end else begin
                        target_n = new_target;
                    end
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Every output is forced low while reset is asserted.
    assign imemREN      = nRST & req;
    assign imemaddr     = nRST ? addr : '0;
    assign latch_en     = nRST & en;
    assign latch_flush  = nRST & flush;
    assign latch_freeze = nRST & (stall | (state == HALTED));
    assign instr_o      = nRST ? d_instr : '0;
    assign npc_o        = nRST ? d_npc : '0;
    assign curr_pc_o    = nRST ? d_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, redirect_valid, halt;
    logic [31:0] iload, redirect_pc;
    logic        imemREN, latch_en, latch_flush, latch_freeze;
    logic [31:0] imemaddr, instr_o, npc_o, curr_pc_o;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.RESET_PC(32'h0), .PC_INC(4)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .iload          (iload),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_o        (instr_o),
        .npc_o          (npc_o),
        .curr_pc_o      (curr_pc_o),
        .latch_en       (latch_en),
        .latch_flush    (latch_flush),
        .latch_freeze   (latch_freeze)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every latch_en pulse must match the oldest expected delivery.
    always @(negedge CLK) begin
        exp_t e;
        if (latch_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_en: latch_en=1 curr_pc_o=%h, no delivery expected", curr_pc_o);
            end else begin
                e = sb.pop_front();
                if ({instr_o, curr_pc_o, npc_o} !== e) begin
                    errors++;
                    $display("FAIL sb_delivery: got instr=%h pc=%h npc=%h want instr=%h pc=%h npc=%h",
                             instr_o, curr_pc_o, npc_o, e.instr, e.pc, e.npc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 0; stall = 0; redirect_valid = 0; halt = 0;
        iload = 32'h0; redirect_pc = 32'h0;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        sb.push_back('{instr: instr, pc: pc, npc: pc + 32'd4});
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0; ihit = 1; iload = 32'h1234_5678; stall = 1;
        @(negedge CLK);
        checks++;
        if ({imemREN, latch_en, latch_flush, latch_freeze, imemaddr, instr_o, npc_o, curr_pc_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ren=%b en=%b fl=%b fz=%b addr=%h instr=%h want all 0",
                     imemREN, latch_en, latch_flush, latch_freeze, imemaddr, instr_o);
        end
        next_cycle();
        idle_inputs();
        nRST = 1;
        @(negedge CLK);
        checks++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_fetch: got ren=%b addr=%h want ren=1 addr=0", imemREN, imemaddr);
        end
        next_cycle();
    endtask

    task automatic test_stream();
        for (int n = 0; n < 2; n++) begin
            ihit = 1; iload = 32'hA0 + n;
            push(32'hA0 + n, 32'(4 * n));
            @(negedge CLK);
            checks++;
            if (imemaddr !== 32'(4 * n) || latch_en !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got addr=%h en=%b want addr=%h en=1", n, imemaddr, latch_en, 32'(4 * n));
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_stall_hold();
        ihit = 1; stall = 1; iload = 32'hDEAD_BEEF;
        @(negedge CLK);
        checks++;
        if (imemaddr !== 32'h8 || latch_en !== 1'b0 || latch_freeze !== 1'b1) begin
            errors++;
            $display("FAIL stall_capture: got addr=%h en=%b fz=%b want addr=8 en=0 fz=1", imemaddr, latch_en, latch_freeze);
        end
        next_cycle();
        ihit = 0; iload = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (imemREN !== 1'b0 || latch_freeze !== 1'b1 || latch_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: got ren=%b fz=%b en=%b want ren=0 fz=1 en=0", i, imemREN, latch_freeze, latch_en);
            end
            next_cycle();
        end
        stall = 0;
        push(32'hDEAD_BEEF, 32'h8);
        @(negedge CLK);
        checks++;
        if (latch_en !== 1'b1 || imemREN !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got en=%b ren=%b want en=1 ren=0", latch_en, imemREN);
        end
        next_cycle();
        ihit = 1; iload = 32'hA3;
        push(32'hA3, 32'hC);
        @(negedge CLK);
        checks++;
        if (imemaddr !== 32'hC || imemREN !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got addr=%h ren=%b want addr=c ren=1", imemaddr, imemREN);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_kill();
        redirect_valid = 1; redirect_pc = 32'h103;
        @(negedge CLK);
        checks++;
        if (latch_flush !== 1'b1 || imemaddr !== 32'h10 || latch_en !== 1'b0) begin
            errors++;
            $display("FAIL kill_enter: got fl=%b addr=%h en=%b want fl=1 addr=10 en=0", latch_flush, imemaddr, latch_en);
        end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h10 || latch_flush !== 1'b0) begin
            errors++;
            $display("FAIL kill_wait: got ren=%b addr=%h fl=%b want ren=1 addr=10 fl=0", imemREN, imemaddr, latch_flush);
        end
        next_cycle();
        ihit = 1; iload = 32'hBAD0_0BAD;
        @(negedge CLK);
        checks++;
        if (latch_en !== 1'b0 || imemaddr !== 32'h10) begin
            errors++;
            $display("FAIL kill_discard: got en=%b addr=%h want en=0 addr=10", latch_en, imemaddr);
        end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (imemaddr !== 32'h100) begin
            errors++;
            $display("FAIL kill_target: got addr=%h want addr=100", imemaddr);
        end
        next_cycle();
    endtask

    task automatic test_double_redirect();
        redirect_valid = 1; redirect_pc = 32'h200;
        @(negedge CLK);
        checks++;
        if (latch_flush !== 1'b1) begin
            errors++;
            $display("FAIL redir1_flush: got fl=%b want fl=1", latch_flush);
        end
        next_cycle();
        redirect_pc = 32'h300;
        @(negedge CLK);
        checks++;
        if (latch_flush !== 1'b1 || imemaddr !== 32'h100) begin
            errors++;
            $display("FAIL redir2_flush: got fl=%b addr=%h want fl=1 addr=100", latch_flush, imemaddr);
        end
        next_cycle();
        idle_inputs();
        ihit = 1; iload = 32'hCAFE;
        next_cycle();
        iload = 32'h55;
        push(32'h55, 32'h300);
        @(negedge CLK);
        checks++;
        if (imemaddr !== 32'h300 || latch_en !== 1'b1) begin
            errors++;
            $display("FAIL redir_final: got addr=%h en=%b want addr=300 en=1", imemaddr, latch_en);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_wrap();
        ihit = 1; iload = 32'h99; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge CLK);
        checks++;
        if (latch_en !== 1'b0 || latch_flush !== 1'b1) begin
            errors++;
            $display("FAIL wrap_redirect: got en=%b fl=%b want en=0 fl=1", latch_en, latch_flush);
        end
        next_cycle();
        redirect_valid = 0; iload = 32'h77;
        push(32'h77, 32'hFFFF_FFFC);
        @(negedge CLK);
        checks++;
        if (imemaddr !== 32'hFFFF_FFFC || npc_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_npc: got addr=%h npc=%h want addr=fffffffc npc=0", imemaddr, npc_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (imemaddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got addr=%h want 0", imemaddr);
        end
    endtask

    task automatic test_halt();
        halt = 1; redirect_valid = 1; redirect_pc = 32'h40; ihit = 1; iload = 32'h11;
        @(negedge CLK);
        checks++;
        if (latch_en !== 1'b0 || latch_flush !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: got en=%b fl=%b want en=0 fl=0", latch_en, latch_flush);
        end
        next_cycle();
        halt = 0;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = (i == 1);
            @(negedge CLK);
            checks++;
            if (imemREN !== 1'b0 || latch_en !== 1'b0 || latch_flush !== 1'b0 || latch_freeze !== 1'b1) begin
                errors++;
                $display("FAIL halted_%0d: got ren=%b en=%b fl=%b fz=%b want ren=0 en=0 fl=0 fz=1",
                         i, imemREN, latch_en, latch_flush, latch_freeze);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset_hold();
        nRST = 0;
        #2;
        nRST = 1;
        next_cycle();
        ihit = 1; stall = 1; iload = 32'h4242;
        next_cycle();
        ihit = 0;
        #2;
        nRST = 0;
        #1;
        checks++;
        if ({imemREN, latch_en, latch_flush, latch_freeze, imemaddr, instr_o, npc_o, curr_pc_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got ren=%b en=%b fl=%b fz=%b addr=%h instr=%h want all 0",
                     imemREN, latch_en, latch_flush, latch_freeze, imemaddr, instr_o);
        end
        next_cycle();
        idle_inputs();
        nRST = 1;
        ihit = 1; iload = 32'h66;
        push(32'h66, 32'h0);
        @(negedge CLK);
        checks++;
        if (imemREN !== 1'b1 || imemaddr !== 32'h0 || latch_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart: got ren=%b addr=%h en=%b want ren=1 addr=0 en=1", imemREN, imemaddr, latch_en);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_kill();
        test_double_redirect();
        test_wrap();
        test_halt();
        test_async_reset_hold();
        @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d undelivered want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
